// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin Wishbone B4 arbiter, NM masters to one slave
// Grant is held for a master's whole cyc; a watchdog errors out stalled strobes.
module wb_bus_arbiter #(
  parameter int NM      = 2,
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NM*WB_AW-1:0]     wbm_adr_i,
  input  logic [NM*WB_DW-1:0]     wbm_dat_i,
  input  logic [NM*WB_DW/8-1:0]   wbm_sel_i,
  input  logic [NM-1:0]           wbm_we_i,
  input  logic [NM-1:0]           wbm_cyc_i,
  input  logic [NM-1:0]           wbm_stb_i,
  input  logic [NM*3-1:0]         wbm_cti_i,
  input  logic [NM*2-1:0]         wbm_bte_i,
  output logic [WB_DW-1:0]        wbm_dat_o,
  output logic [NM-1:0]           wbm_ack_o,
  output logic [NM-1:0]           wbm_err_o,
  output logic [WB_AW-1:0]        wbs_adr_o,
  output logic [WB_DW-1:0]        wbs_dat_o,
  output logic [WB_DW/8-1:0]      wbs_sel_o,
  output logic                    wbs_we_o,
  output logic                    wbs_cyc_o,
  output logic                    wbs_stb_o,
  output logic [2:0]              wbs_cti_o,
  output logic [1:0]              wbs_bte_o,
  input  logic [WB_DW-1:0]        wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  output logic [NM-1:0]           grant_o
);

  localparam int LW      = $clog2(NM);
  localparam int SW      = WB_DW / 8;
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TOUT_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit WD_EN   = (TIMEOUT > 0);

  logic [NM-1:0] r_grant;
  logic [LW-1:0] r_last;
  logic [CW-1:0] r_cnt;

  logic          w_busy;
  logic          w_arb;
  logic          w_found;
  logic [LW-1:0] w_win;
  logic [NM-1:0] w_win_oh;
  logic          w_gcyc;
  logic          w_gstb;
  logic          w_tout;

  // Scan last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= NM; k++) begin
      if (!w_found && wbm_cyc_i[(int'(r_last) + k) % NM]) begin
        w_found = 1'b1;
        w_win   = LW'((int'(r_last) + k) % NM);
      end
    end
    w_win_oh = w_found ? (NM'(1) << w_win) : '0;
  end

  always_comb begin
    w_gcyc    = 1'b0;
    w_gstb    = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_grant[i]) begin
        w_gcyc    = wbm_cyc_i[i];
        w_gstb    = wbm_stb_i[i] & wbm_cyc_i[i];
        wbs_adr_o = wbm_adr_i[i*WB_AW +: WB_AW];
        wbs_dat_o = wbm_dat_i[i*WB_DW +: WB_DW];
        wbs_sel_o = wbm_sel_i[i*SW +: SW];
        wbs_we_o  = wbm_we_i[i];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign w_busy    = |r_grant;
  assign w_arb     = !w_busy || !w_gcyc;
  assign w_tout    = WD_EN && w_gstb && !wbs_ack_i && (r_cnt == CW'(TOUT_M1));

  assign wbs_cyc_o = w_gcyc;
  assign wbs_stb_o = w_gstb;
  assign wbm_dat_o = w_busy ? wbs_dat_i : '0;
  assign wbm_ack_o = r_grant & {NM{wbs_ack_i}};
  assign wbm_err_o = r_grant & {NM{wbs_err_i | w_tout}};
  assign grant_o   = r_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_last  <= LW'(NM - 1);
      r_cnt   <= '0;
    end else begin
      if (w_arb) begin
        r_grant <= w_win_oh;
        r_last  <= w_win;
      end
      if (w_arb || !WD_EN || wbs_ack_i || wbs_err_i || w_tout)
        r_cnt <= '0;
      else if (w_gstb)
        r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - scoreboard bench for wb_bus_arbiter (NM=2, TIMEOUT=8)
module tb_wb_bus_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NM*AW-1:0]     wbm_adr_i;
  logic [NM*DW-1:0]     wbm_dat_i;
  logic [NM*DW/8-1:0]   wbm_sel_i;
  logic [NM-1:0]        wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [NM*3-1:0]      wbm_cti_i;
  logic [NM*2-1:0]      wbm_bte_i;
  logic [DW-1:0]        wbm_dat_o;
  logic [NM-1:0]        wbm_ack_o, wbm_err_o;
  logic [AW-1:0]        wbs_adr_o;
  logic [DW-1:0]        wbs_dat_o;
  logic [DW/8-1:0]      wbs_sel_o;
  logic                 wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]           wbs_cti_o;
  logic [1:0]           wbs_bte_o;
  logic [DW-1:0]        wbs_dat_i;
  logic                 wbs_ack_i, wbs_err_i;
  logic [NM-1:0]        grant_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  wb_bus_arbiter #(.NM(NM), .WB_AW(AW), .WB_DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o(grant_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
    wbm_cyc_i[m]           = cyc;
    wbm_stb_i[m]           = stb;
    wbm_we_i[m]            = 1'b1;
    wbm_adr_i[m*AW +: AW]  = adr;
    wbm_dat_i[m*DW +: DW]  = adr ^ 32'h5a5a_0000;
    wbm_sel_i[m*4 +: 4]    = 4'hf;
    wbm_cti_i[m*3 +: 3]    = cti;
    wbm_bte_i[m*2 +: 2]    = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'hdead_beef;
    tick();
    tick();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
    n_cmp++; if (wbs_cyc_o !== 1'b0) begin n_bad++; $display("FAIL reset_cyc: got %b expected 0", wbs_cyc_o); end
    n_cmp++; if (wbm_ack_o !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b expected 00", wbm_ack_o); end
    n_cmp++; if (wbm_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat: got %h expected 0", wbm_dat_o); end
    rst = 1'b0;
    wbs_ack_i = 1'b0;
    tick();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL idle_grant: got %b expected 00", grant_o); end
  endtask

  task automatic test_handoff();
    logic [31:0] e;
    drive_m(0, 1'b1, 1'b1, 32'h1000, 3'b000);
    drive_m(1, 1'b1, 1'b1, 32'h2000, 3'b000);
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h2000);
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL first_grant: got %b expected 01", grant_o); end
    e = exp_q.pop_front();
    n_cmp++; if (wbs_adr_o !== e) begin n_bad++; $display("FAIL first_adr: got %h expected %h", wbs_adr_o, e); end
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'hcafe_0001;
    #1;
    n_cmp++; if (wbm_ack_o !== 2'b01) begin n_bad++; $display("FAIL ack_route: got %b expected 01", wbm_ack_o); end
    n_cmp++; if (wbm_dat_o !== 32'hcafe_0001) begin n_bad++; $display("FAIL dat_bcast: got %h expected cafe0001", wbm_dat_o); end
    tick();
    drive_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    wbs_ack_i = 1'b0;
    #1;
    n_cmp++; if (wbs_cyc_o !== 1'b0) begin n_bad++; $display("FAIL release_cyc: got %b expected 0", wbs_cyc_o); end
    tick();
    n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL handoff_grant: got %b expected 10", grant_o); end
    e = exp_q.pop_front();
    n_cmp++; if (wbs_adr_o !== e) begin n_bad++; $display("FAIL handoff_adr: got %h expected %h", wbs_adr_o, e); end
    wbs_ack_i = 1'b1;
    tick();
    drive_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    wbs_ack_i = 1'b0;
    tick();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL idle_after: got %b expected 00", grant_o); end
  endtask

  task automatic test_burst();
    logic [31:0] e;
    logic [31:0] adr;
    logic [2:0]  cti;
    drive_m(1, 1'b1, 1'b1, 32'h3000, 3'b010);
    tick();
    n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL burst_grant: got %b expected 10", grant_o); end
    drive_m(0, 1'b1, 1'b1, 32'h4000, 3'b000);
    for (int b = 0; b < 4; b++) begin
      adr = 32'h3000 + 32'(4 * b);
      cti = (b == 3) ? 3'b111 : 3'b010;
      exp_q.push_back({adr[28:0], cti});
      drive_m(1, 1'b1, 1'b1, adr, cti);
      wbs_ack_i = 1'b1;
      #1;
      n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL burst_hold%0d: got %b expected 10", b, grant_o); end
      e = exp_q.pop_front();
      n_cmp++; if ({wbs_adr_o[28:0], wbs_cti_o} !== e) begin n_bad++; $display("FAIL burst_beat%0d: got %h expected %h", b, {wbs_adr_o[28:0], wbs_cti_o}, e); end
      tick();
    end
    drive_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    wbs_ack_i = 1'b0;
    #1;
    n_cmp++; if (wbm_ack_o !== 2'b00) begin n_bad++; $display("FAIL waiter_ack: got %b expected 00", wbm_ack_o); end
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL after_burst: got %b expected 01", grant_o); end
    n_cmp++; if (wbs_adr_o !== 32'h4000) begin n_bad++; $display("FAIL after_burst_adr: got %h expected 4000", wbs_adr_o); end
  endtask

  task automatic test_alternate();
    logic [31:0] g;
    logic [1:0]  eg;
    drive_m(1, 1'b1, 1'b1, 32'h6000, 3'b000);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i % 2));
    for (int it = 0; it < 6; it++) begin
      g  = exp_q.pop_front();
      eg = (g == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (grant_o !== eg) begin n_bad++; $display("FAIL rr_%0d: got %b expected %b", it, grant_o, eg); end
      wbs_ack_i = 1'b1;
      tick();
      drive_m(int'(g), 1'b0, 1'b0, 32'h0, 3'b000);
      wbs_ack_i = 1'b0;
      tick();
      drive_m(int'(g), 1'b1, 1'b1, 32'h5000 + g, 3'b000);
    end
    drive_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    wbs_ack_i = 1'b1;
    tick();
    drive_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    wbs_ack_i = 1'b0;
    tick();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rr_idle: got %b expected 00", grant_o); end
    drive_m(0, 1'b1, 1'b1, 32'h5100, 3'b000);
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL rr_repeat: got %b expected 01", grant_o); end
  endtask

  task automatic test_timeout();
    logic [31:0] e;
    logic [1:0]  ee;
    drive_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    drive_m(0, 1'b1, 1'b1, 32'h7000, 3'b000);
    for (int j = 0; j < 16; j++) exp_q.push_back((j == TO - 1) ? 32'd1 : 32'd0);
    tick();
    for (int j = 0; j < 16; j++) begin
      wbs_ack_i = (j == 15);
      #1;
      e  = exp_q.pop_front();
      ee = (e != 0) ? 2'b01 : 2'b00;
      n_cmp++; if (wbm_err_o !== ee) begin n_bad++; $display("FAIL wdog_c%0d: got %b expected %b", j, wbm_err_o, ee); end
      if (j == 15) begin
        n_cmp++; if (wbm_ack_o !== 2'b01) begin n_bad++; $display("FAIL wdog_ack: got %b expected 01", wbm_ack_o); end
      end
      tick();
    end
    wbs_ack_i = 1'b0;
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL wdog_grant: got %b expected 01", grant_o); end
    drive_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_reset_mid_burst();
    drive_m(0, 1'b1, 1'b1, 32'h8000, 3'b010);
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL mid_pre: got %b expected 01", grant_o); end
    drive_m(1, 1'b1, 1'b1, 32'h9000, 3'b000);
    wbs_ack_i = 1'b1;
    tick();
    drive_m(0, 1'b1, 1'b1, 32'h8004, 3'b010);
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL mid_hold: got %b expected 01", grant_o); end
    rst = 1'b1;
    tick();
    n_cmp++; if (wbs_cyc_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cyc: got %b expected 0", wbs_cyc_o); end
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL mid_rst_grant: got %b expected 00", grant_o); end
    n_cmp++; if (wbm_ack_o !== 2'b00) begin n_bad++; $display("FAIL mid_rst_ack: got %b expected 00", wbm_ack_o); end
    rst = 1'b0;
    wbs_ack_i = 1'b0;
    tick();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL post_rst_grant: got %b expected 01", grant_o); end
    drive_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    drive_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    wbm_adr_i = '0;
    wbm_dat_i = '0;
    wbm_sel_i = '0;
    wbm_we_i  = '0;
    wbm_cyc_i = '0;
    wbm_stb_i = '0;
    wbm_cti_i = '0;
    wbm_bte_i = '0;
    wbs_dat_i = '0;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    test_reset();
    test_handoff();
    test_burst();
    test_alternate();
    test_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
